// File: rtl/lc3_psr_unit.sv
// LC-3 processor status unit: PSR register, NZP derivation, BR evaluation
// and a shadow-PSR LIFO for nested interrupts / RTI with sticky errors.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cc_we, result    update NZP from execute-stage result
//   psr_we, psr_din  load full PSR (reserved bits ignored)
//   int_take,int_pri push PSR, enter supervisor at int_pri
//   rti              pop shadow PSR
//   err_clr          clear sticky ovf_err / unf_err
//   br_nzp, br_taken BR mask and combinational branch decision
//   psr, nzp, priv, pri, count, stk_full, stk_empty, ovf_err, unf_err
module lc3_psr_unit #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cc_we,
  input  logic [WIDTH-1:0] result,
  input  logic             psr_we,
  input  logic [15:0]      psr_din,
  input  logic             int_take,
  input  logic [2:0]       int_pri,
  input  logic             rti,
  input  logic             err_clr,
  input  logic [2:0]       br_nzp,
  output logic             br_taken,
  output logic [15:0]      psr,
  output logic [2:0]       nzp,
  output logic             priv,
  output logic [2:0]       pri,
  output logic [CW-1:0]    count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             ovf_err,
  output logic             unf_err
);

  // Only the architecturally meaningful bits {priv, pri, nzp} are saved;
  // the reserved PSR bits are constant zero and need no storage.
  logic [6:0] stack [DEPTH];

  logic [6:0] pop_val;
  logic [2:0] cc_val;
  logic [2:0] din_nzp;
  logic       do_push, do_ovf, do_pop, do_unf;
  logic       do_load, do_cc;
  logic       unused_din;

  assign unused_din = ^{psr_din[14:11], psr_din[7:3]};

  assign stk_full  = (count == CW'(DEPTH));
  assign stk_empty = (count == '0);
  assign psr       = {priv, 4'b0, pri, 5'b0, nzp};
  assign br_taken  = |(br_nzp & nzp);

  // Single winner per cycle: int_take > rti > psr_we > cc_we.
  always_comb begin
    do_push = int_take & ~stk_full;
    do_ovf  = int_take &  stk_full;
    do_pop  = ~int_take & rti & ~stk_empty;
    do_unf  = ~int_take & rti &  stk_empty;
    do_load = ~int_take & ~rti & psr_we;
    do_cc   = ~int_take & ~rti & ~psr_we & cc_we;
  end

  always_comb begin
    cc_val = 3'b001;
    if (result == '0) begin
      cc_val = 3'b010;
    end else if (result[WIDTH-1]) begin
      cc_val = 3'b100;
    end
  end

  // A loaded NZP that is not one-hot collapses to Z.
  always_comb begin
    din_nzp = 3'b010;
    unique case (psr_din[2:0])
      3'b001, 3'b010, 3'b100: din_nzp = psr_din[2:0];
      default:                din_nzp = 3'b010;
    endcase
  end

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) begin
        pop_val = stack[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && do_push && count == CW'(i)) begin
        stack[i] <= {priv, pri, nzp};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      priv    <= 1'b0;
      pri     <= 3'd0;
      nzp     <= 3'b010;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      unique case (1'b1)
        do_push: begin
          priv  <= 1'b0;
          pri   <= int_pri;
          count <= count + CW'(1);
        end
        do_pop: begin
          priv  <= pop_val[6];
          pri   <= pop_val[5:3];
          nzp   <= pop_val[2:0];
          count <= count - CW'(1);
        end
        do_load: begin
          priv <= psr_din[15];
          pri  <= psr_din[10:8];
          nzp  <= din_nzp;
        end
        do_cc: begin
          nzp <= cc_val;
        end
        default: ;
      endcase

      // Set wins over a same-cycle clear.
      if (do_ovf) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end

      if (do_unf) begin
        unf_err <= 1'b1;
      end else if (err_clr) begin
        unf_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lc3_psr_unit.sv
// Self-checking bench for lc3_psr_unit (WIDTH=16, DEPTH=4):
// directed vector table plus hand-written LIFO / error / reset sequences.
module tb_lc3_psr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cc_we;
  logic [15:0] result;
  logic        psr_we;
  logic [15:0] psr_din;
  logic        int_take;
  logic [2:0]  int_pri;
  logic        rti;
  logic        err_clr;
  logic [2:0]  br_nzp;
  logic        br_taken;
  logic [15:0] psr;
  logic [2:0]  nzp;
  logic        priv;
  logic [2:0]  pri;
  logic [2:0]  count;
  logic        stk_full;
  logic        stk_empty;
  logic        ovf_err;
  logic        unf_err;

  int checks = 0;
  int errors = 0;

  lc3_psr_unit #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cc_we(cc_we), .result(result),
    .psr_we(psr_we), .psr_din(psr_din),
    .int_take(int_take), .int_pri(int_pri),
    .rti(rti), .err_clr(err_clr),
    .br_nzp(br_nzp), .br_taken(br_taken),
    .psr(psr), .nzp(nzp), .priv(priv), .pri(pri),
    .count(count), .stk_full(stk_full), .stk_empty(stk_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cc_we;
    logic [15:0] result;
    logic        psr_we;
    logic [15:0] din;
    logic        it;
    logic [2:0]  ip;
    logic        rti;
    logic        ec;
    logic [2:0]  br;
    logic [15:0] e_psr;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
    logic        e_br;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(
    input logic cw, input logic [15:0] res,
    input logic pw, input logic [15:0] din,
    input logic it, input logic [2:0] ip,
    input logic rt, input logic ec, input logic [2:0] br,
    input logic [15:0] ep, input logic [2:0] ecn,
    input logic eo, input logic eu, input logic eb);
    vec_t v;
    v.cc_we = cw; v.result = res; v.psr_we = pw; v.din = din;
    v.it = it; v.ip = ip; v.rti = rt; v.ec = ec; v.br = br;
    v.e_psr = ep; v.e_cnt = ecn; v.e_ovf = eo; v.e_unf = eu;
    v.e_br = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] ep,
                           input logic [2:0] ecn, input logic eo,
                           input logic eu);
    chk({tag, " psr"}, psr, ep);
    chk({tag, " nzp"}, {13'b0, nzp}, {13'b0, ep[2:0]});
    chk({tag, " priv"}, {15'b0, priv}, {15'b0, ep[15]});
    chk({tag, " pri"}, {13'b0, pri}, {13'b0, ep[10:8]});
    chk({tag, " count"}, {13'b0, count}, {13'b0, ecn});
    chk({tag, " full"}, {15'b0, stk_full}, {15'b0, ecn == 3'd4});
    chk({tag, " empty"}, {15'b0, stk_empty}, {15'b0, ecn == 3'd0});
    chk({tag, " ovf"}, {15'b0, ovf_err}, {15'b0, eo});
    chk({tag, " unf"}, {15'b0, unf_err}, {15'b0, eu});
  endtask

  task automatic idle();
    rst = 1'b0; cc_we = 1'b0; result = '0; psr_we = 1'b0;
    psr_din = '0; int_take = 1'b0; int_pri = '0; rti = 1'b0;
    err_clr = 1'b0; br_nzp = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [2:0] p, input logic ec);
    int_take = 1'b1; int_pri = p; err_clr = ec;
    step();
  endtask

  task automatic pop();
    rti = 1'b1;
    step();
  endtask

  initial begin
    // cc_we sequence, load/push/pop, priority and error flag cases.
    vecs[0]  = mk(1, 16'h8000, 0, 0, 0, 0, 0, 0, 3'b011,
                  16'h0004, 0, 0, 0, 0);
    vecs[1]  = mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 3'b011,
                  16'h0002, 0, 0, 0, 1);
    vecs[2]  = mk(1, 16'h0001, 0, 0, 0, 0, 0, 0, 3'b011,
                  16'h0001, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 1, 16'h8203, 0, 0, 0, 0, 3'b011,
                  16'h8202, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 1, 3'd4, 0, 0, 3'b010,
                  16'h0402, 1, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b100,
                  16'h8202, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 16'h0000, 0, 0, 0, 0, 3'b010,
                  16'h0002, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 1, 16'hFFFC, 0, 0, 0, 0, 3'b100,
                  16'h8704, 0, 0, 0, 1);
    vecs[8]  = mk(1, 16'hFFFF, 0, 0, 1, 3'd2, 1, 0, 3'b001,
                  16'h0204, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 16'h0001, 0, 0, 1, 0, 3'b100,
                  16'h8704, 0, 0, 0, 1);
    vecs[10] = mk(1, 16'h0005, 1, 16'h0002, 0, 0, 0, 0, 3'b001,
                  16'h0002, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b010,
                  16'h0002, 0, 0, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'b101,
                  16'h0002, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 3'b111,
                  16'h0002, 0, 0, 1, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'b000,
                  16'h0002, 0, 0, 0, 0);

    idle();
    rst = 1'b1;
    step();
    chk_state("reset", 16'h0002, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      cc_we = vecs[i].cc_we; result = vecs[i].result;
      psr_we = vecs[i].psr_we; psr_din = vecs[i].din;
      int_take = vecs[i].it; int_pri = vecs[i].ip;
      rti = vecs[i].rti; err_clr = vecs[i].ec;
      @(posedge clk);
      #1;
      br_nzp = vecs[i].br;
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_psr,
                vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
      chk($sformatf("vec%0d br_taken", i), {15'b0, br_taken},
          {15'b0, vecs[i].e_br});
      idle();
    end

    // Nested interrupts past DEPTH, then unwind past empty.
    psr_we = 1'b1; psr_din = 16'h8001;
    step();
    chk_state("orig", 16'h8001, 0, 0, 0);
    push(3'd1, 1'b0); chk_state("push1", 16'h0101, 1, 0, 0);
    push(3'd2, 1'b0); chk_state("push2", 16'h0201, 2, 0, 0);
    push(3'd3, 1'b0); chk_state("push3", 16'h0301, 3, 0, 0);
    push(3'd4, 1'b0); chk_state("push4", 16'h0401, 4, 0, 0);
    push(3'd5, 1'b1); chk_state("push5", 16'h0401, 4, 1, 0);
    err_clr = 1'b1;
    step();
    chk_state("clr", 16'h0401, 4, 0, 0);
    pop(); chk_state("pop1", 16'h0301, 3, 0, 0);
    pop(); chk_state("pop2", 16'h0201, 2, 0, 0);
    pop(); chk_state("pop3", 16'h0101, 1, 0, 0);
    pop(); chk_state("pop4", 16'h8001, 0, 0, 0);
    pop(); chk_state("pop5", 16'h8001, 0, 0, 1);

    // Reset with three entries stacked and a same-cycle request.
    push(3'd6, 1'b0);
    push(3'd7, 1'b0);
    push(3'd3, 1'b0);
    chk_state("pre_rst", 16'h0301, 3, 0, 1);
    rst = 1'b1; int_take = 1'b1; int_pri = 3'd5;
    step();
    chk_state("rst_mid", 16'h0002, 0, 0, 0);
    pop();
    chk_state("rti_after_rst", 16'h0002, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
